// File: rtl/serial_magnitude_compare.sv
// ---------------------------------------------------------------------------
// serial_magnitude_compare
//
// Purpose:
//   Low-area magnitude comparator that walks two WIDTH-bit operands one bit
//   per clock, MSB first, using the classic compare-slice recurrence on a
//   registered equal/less pair. The scan stops at the first differing bit,
//   so the latency depends on the data. Unsigned and two's-complement
//   compares are both supported. In signed mode the sign bits are inverted
//   when the operands are latched, which maps signed order onto unsigned
//   order.
//
// Ports:
//   clk          in   1      rising-edge clock
//   rst_n        in   1      synchronous reset, active-low
//   start        in   1      request a compare (ignored while busy)
//   signed_mode  in   1      1 = two's-complement compare, 0 = unsigned
//   a, b         in   WIDTH  operands, sampled together with start
//   busy         out  1      high while the bit scan is running
//   done         out  1      one-cycle pulse, results valid
//   a_eq_b       out  1      result A == B
//   a_lt_b       out  1      result A <  B
//   a_gt_b       out  1      result A >  B
// ---------------------------------------------------------------------------
module serial_magnitude_compare #(
  parameter  int WIDTH = 8,
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             a_eq_b,
  output logic             a_lt_b,
  output logic             a_gt_b
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             e_q, e_d;
  logic             l_q, l_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             eq_q, eq_d;
  logic             lt_q, lt_d;
  logic             gt_q, gt_d;

  logic [WIDTH-1:0] sign_mask;
  logic [WIDTH-1:0] a_shift;
  logic [WIDTH-1:0] b_shift;
  logic             ai;
  logic             bi;
  logic             e_next;
  logic             l_next;
  logic             stop;

  // Datapath for the current bit: select A[idx]/B[idx] and apply one step
  // of the compare-slice recurrence. Shifting instead of indexing keeps the
  // WIDTH=1 case free of out-of-range selects.
  always_comb begin
    sign_mask            = '0;
    sign_mask[WIDTH-1]   = signed_mode;
    a_shift              = a_q >> idx_q;
    b_shift              = b_q >> idx_q;
    ai                   = a_shift[0];
    bi                   = b_shift[0];
    e_next               = e_q & ~(ai ^ bi);
    l_next               = l_q | (~ai & bi & e_q);
    stop                 = (ai != bi) || (idx_q == '0);
  end

  // Next-state and register-input logic. Every register holds by default;
  // the result registers only change when a scan terminates, so they keep
  // the previous compare's answer until the new done.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    e_d     = e_q;
    l_d     = l_q;
    idx_d   = idx_q;
    eq_d    = eq_q;
    lt_d    = lt_q;
    gt_d    = gt_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = a ^ sign_mask;
          b_d     = b ^ sign_mask;
          e_d     = 1'b1;
          l_d     = 1'b0;
          idx_d   = IDX_TOP;
          state_d = SCAN;
        end else begin
          state_d = IDLE;
        end
      end

      SCAN: begin
        e_d = e_next;
        l_d = l_next;
        if (stop) begin
          eq_d    = e_next;
          lt_d    = l_next;
          gt_d    = ~e_next & ~l_next;
          state_d = DONE;
        end else begin
          idx_d = idx_q - IDX_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and data registers with synchronous active-low reset. Reset
  // drops any compare in flight, so no done pulse follows it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      e_q     <= 1'b1;
      l_q     <= 1'b0;
      idx_q   <= IDX_TOP;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
      gt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      e_q     <= e_d;
      l_q     <= l_d;
      idx_q   <= idx_d;
      eq_q    <= eq_d;
      lt_q    <= lt_d;
      gt_q    <= gt_d;
    end
  end

  // Status and results come straight from registers.
  assign busy   = (state_q == SCAN);
  assign done   = (state_q == DONE);
  assign a_eq_b = eq_q;
  assign a_lt_b = lt_q;
  assign a_gt_b = gt_q;

endmodule

// File: tb/tb_serial_magnitude_compare.sv
// ---------------------------------------------------------------------------
// tb_serial_magnitude_compare
//
// Self-checking bench for serial_magnitude_compare. It covers an 8-bit
// instance with directed vectors and a random sweep, plus a 1-bit instance
// exercised exhaustively. Inputs are driven and outputs sampled on the
// falling clock edge.
// ---------------------------------------------------------------------------
module tb_serial_magnitude_compare;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       signedMode;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic       aEqB;
  logic       aLtB;
  logic       aGtB;

  logic       start1;
  logic       signedMode1;
  logic       a1;
  logic       b1;
  logic       busy1;
  logic       done1;
  logic       aEqB1;
  logic       aLtB1;
  logic       aGtB1;

  int         errors;
  int         checks;
  logic [2:0] prevRes;

  localparam logic [2:0] RES_EQ = 3'b100;
  localparam logic [2:0] RES_LT = 3'b010;
  localparam logic [2:0] RES_GT = 3'b001;

  serial_magnitude_compare #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .signed_mode (signedMode),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .a_eq_b      (aEqB),
    .a_lt_b      (aLtB),
    .a_gt_b      (aGtB)
  );

  serial_magnitude_compare #(.WIDTH(1)) dut1 (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start1),
    .signed_mode (signedMode1),
    .a           (a1),
    .b           (b1),
    .busy        (busy1),
    .done        (done1),
    .a_eq_b      (aEqB1),
    .a_lt_b      (aLtB1),
    .a_gt_b      (aGtB1)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Cycles from start to done for an 8-bit compare: 1 + distance of the
  // highest differing bit from the MSB, or 8 when the operands are equal.
  // The sign-bit flip does not change which bits differ.
  function automatic int expLatency(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] diff;
    diff = x ^ y;
    for (int i = 7; i >= 0; i--) begin
      if (diff[i]) return 8 - i;
    end
    return 8;
  endfunction

  // Issue one 8-bit compare from a falling edge and follow it until done.
  // Checks busy and result hold in cycle 1, then latency and result at done.
  // Returns at the falling edge inside the DONE cycle.
  task automatic applyStimulus(input string tag, input logic sm,
                               input logic [7:0] av, input logic [7:0] bv,
                               input int k, input logic [2:0] expRes);
    int cyc;
    start      = 1'b1;
    signedMode = sm;
    a          = av;
    b          = bv;
    @(negedge clk);
    start      = 1'b0;
    a          = 8'($urandom);
    b          = 8'($urandom);
    signedMode = 1'($urandom);
    checkOutput({tag, " busy"}, 32'(busy), 32'd1);
    checkOutput({tag, " hold"}, 32'({aEqB, aLtB, aGtB}), 32'(prevRes));
    cyc = 1;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput({tag, " latency"}, 32'(cyc), 32'(k + 1));
    checkOutput({tag, " result"}, 32'({aEqB, aLtB, aGtB}), 32'(expRes));
    prevRes = expRes;
  endtask

  // One cycle after done with no new start: back to idle, pulse gone.
  task automatic checkIdle(input string tag);
    @(negedge clk);
    checkOutput({tag, " idle"}, 32'({busy, done}), 32'd0);
  endtask

  // One 1-bit compare: a single scan cycle, done in cycle 2.
  task automatic runW1(input logic sm, input logic av, input logic bv,
                       input logic [2:0] expRes);
    start1      = 1'b1;
    signedMode1 = sm;
    a1          = av;
    b1          = bv;
    @(negedge clk);
    start1      = 1'b0;
    a1          = ~av;
    b1          = ~bv;
    checkOutput("w1 busy", 32'(busy1), 32'd1);
    @(negedge clk);
    checkOutput("w1 done", 32'(done1), 32'd1);
    checkOutput($sformatf("w1 result sm=%0d a=%0d b=%0d", sm, av, bv),
                32'({aEqB1, aLtB1, aGtB1}), 32'(expRes));
    @(negedge clk);
    checkOutput("w1 idle", 32'({busy1, done1}), 32'd0);
  endtask

  initial begin
    int         cyc;
    logic       sawDone;
    logic [7:0] ra;
    logic [7:0] rb;
    logic       rs;
    logic       isLt;
    logic [2:0] er;

    errors      = 0;
    checks      = 0;
    prevRes     = 3'b000;
    rst_n       = 1'b0;
    start       = 1'b0;
    signedMode  = 1'b0;
    a           = '0;
    b           = '0;
    start1      = 1'b0;
    signedMode1 = 1'b0;
    a1          = 1'b0;
    b1          = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("reset outputs", 32'({busy, done, aEqB, aLtB, aGtB}), 32'd0);
    checkOutput("reset outputs w1", 32'({busy1, done1, aEqB1, aLtB1, aGtB1}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed 8-bit vectors
    applyStimulus("eq A5", 1'b0, 8'hA5, 8'hA5, 8, RES_EQ);
    checkIdle("eq A5");
    applyStimulus("u 80v7F", 1'b0, 8'h80, 8'h7F, 1, RES_GT);
    checkIdle("u 80v7F");
    applyStimulus("s 80v7F", 1'b1, 8'h80, 8'h7F, 1, RES_LT);
    checkIdle("s 80v7F");
    applyStimulus("u 12v13", 1'b0, 8'h12, 8'h13, 8, RES_LT);
    checkIdle("u 12v13");
    applyStimulus("s FFvFE", 1'b1, 8'hFF, 8'hFE, 8, RES_GT);
    checkIdle("s FFvFE");

    // Start while busy is ignored; then a back-to-back start in DONE
    start      = 1'b1;
    signedMode = 1'b0;
    a          = 8'h00;
    b          = 8'h00;
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
    repeat (2) begin
      @(negedge clk);
      cyc++;
    end
    start = 1'b1;
    a     = 8'h01;
    b     = 8'h02;
    @(negedge clk);
    cyc++;
    start = 1'b0;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("ignore latency", 32'(cyc), 32'd9);
    checkOutput("ignore result", 32'({aEqB, aLtB, aGtB}), 32'(RES_EQ));
    prevRes = RES_EQ;
    applyStimulus("b2b 03v01", 1'b0, 8'h03, 8'h01, 7, RES_GT);
    checkIdle("b2b 03v01");

    // Reset in the middle of a scan
    start      = 1'b1;
    signedMode = 1'b0;
    a          = 8'h00;
    b          = 8'h01;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("midscan reset", 32'({busy, done, aEqB, aLtB, aGtB}), 32'd0);
    rst_n   = 1'b1;
    prevRes = 3'b000;
    sawDone = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (done || busy) sawDone = 1'b1;
    end
    checkOutput("no done after reset", 32'(sawDone), 32'd0);
    applyStimulus("post reset 40v20", 1'b0, 8'h40, 8'h20, 2, RES_GT);
    checkIdle("post reset 40v20");

    // 1-bit instance, all operand pairs in both modes
    for (int m = 0; m < 2; m++) begin
      for (int x = 0; x < 2; x++) begin
        for (int y = 0; y < 2; y++) begin
          if (x == y) er = RES_EQ;
          else if ((m == 1) ? (x > y) : (x < y)) er = RES_LT;
          else er = RES_GT;
          runW1(1'(m), 1'(x), 1'(y), er);
        end
      end
    end

    // Random sweep against a $signed/unsigned reference
    for (int i = 0; i < 200; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rs = 1'($urandom);
      if (i % 8 == 0) rb = ra;
      else if (i % 8 == 1) rb = ra ^ 8'(1 << $urandom_range(7, 0));
      isLt = rs ? ($signed(ra) < $signed(rb)) : (ra < rb);
      if (ra == rb) er = RES_EQ;
      else if (isLt) er = RES_LT;
      else er = RES_GT;
      applyStimulus($sformatf("rand%0d s=%0d %02hv%02h", i, rs, ra, rb),
                    rs, ra, rb, expLatency(ra, rb), er);
      if (i % 2 == 1) checkIdle("rand");
    end
    checkIdle("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
